match_controller: RTL and testbench

- Sequences a full tug-of-war match on top of the existing light field and victory detector.
- Responsibilities:
  - Arbitrates the player and computer move pulses.
  - Counts round wins per side.
  - Freezes the field for a hold-off period after each round.
  - Issues a one-cycle field reset to start the next round.
  - Declares the match winner when a side reaches MATCH_POINTS.
- Sits between the User_Input pulse conditioners and the light chain / check_victory.

---
 rtl/tow_pkg.sv | 21 ++
 rtl/down_timer.sv | 35 +++
 rtl/match_controller.sv | 150 +++++++++++++++
 tb/tb_match_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war match sequencing logic.
package tow_pkg;

    typedef enum logic [1:0] {
        START,
        PLAY,
        HOLD,
        MATCH_END
    } match_state_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    localparam int DEFAULT_SCORE_W = 3;

    // Bits needed to hold a down-count starting at n-1 (never less than one).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter that stops at zero; zero flags the terminal count.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// Match sequencer for the tug-of-war game: move arbitration, round scoring, hold-off, field reset.
// Optional round timeout (draw on expiry) is built when ROUND_TIMEOUT_EN is defined.
//
// state     | meaning
// START     | one-cycle field_reset, then PLAY
// PLAY      | moves pass through; a win (or timeout) scores and enters HOLD
// HOLD      | field frozen for HOLD_CYCLES; exits to MATCH_END or START
// MATCH_END | match decided; waits for restart
module match_controller
    import tow_pkg::*;
#(
    parameter int MATCH_POINTS = 3,
    parameter int HOLD_CYCLES  = 4,
    parameter int SCORE_W      = DEFAULT_SCORE_W
`ifdef ROUND_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L_press,
    input  logic               R_press,
    input  logic               win_left,
    input  logic               win_right,
    input  logic               restart,
    output logic               L_move,
    output logic               R_move,
    output logic               field_reset,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               match_over,
    output logic               match_winner
);

    localparam int                 HOLD_W    = cnt_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(MATCH_POINTS);

    match_state_t       state_q, state_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               l_move_q, l_move_d;
    logic               r_move_q, r_move_d;
    logic               hold_load, hold_en, hold_zero;
    logic               timeout;
    logic               left_at_max, right_at_max;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= MAX_SCORE) ? s : s + SCORE_W'(1);
    endfunction

    down_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .zero     (hold_zero)
    );

`ifdef ROUND_TIMEOUT_EN
    localparam int RT_W = cnt_w(TIMEOUT_CYCLES);
    logic round_zero;

    down_timer #(.WIDTH(RT_W)) u_round_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == START),
        .load_val (RT_W'(TIMEOUT_CYCLES - 1)),
        .en       (state_q == PLAY),
        .zero     (round_zero)
    );

    assign timeout = (state_q == PLAY) && round_zero;
`else
    assign timeout = 1'b0;
`endif

    assign left_at_max  = (score_left_q == MAX_SCORE);
    assign right_at_max = (score_right_q == MAX_SCORE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= START;
            score_left_q  <= '0;
            score_right_q <= '0;
            l_move_q      <= 1'b0;
            r_move_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            l_move_q      <= l_move_d;
            r_move_q      <= r_move_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        hold_load     = 1'b0;
        hold_en       = 1'b0;
        case (state_q)
            START: state_d = PLAY;
            PLAY: begin
                // A win in the timeout cycle still scores; a double win is a draw.
                if (win_left || win_right || timeout) begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                    if (win_left && !win_right)  score_left_d  = sat_inc(score_left_q);
                    if (win_right && !win_left)  score_right_d = sat_inc(score_right_q);
                end
            end
            HOLD: begin
                hold_en = 1'b1;
                if (hold_zero) begin
                    state_d = (left_at_max || right_at_max) ? MATCH_END : START;
                end
            end
            MATCH_END: begin
                if (restart) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    state_d       = START;
                end
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        l_move_d = 1'b0;
        r_move_d = 1'b0;
        if (state_q == PLAY) begin
            l_move_d = L_press & ~R_press & ~win_left & ~win_right;
            r_move_d = R_press & ~L_press & ~win_left & ~win_right;
        end
        // Gated so the pulse stays low while reset is held and fires right after release.
        field_reset  = (state_q == START) & reset;
        match_over   = (state_q == MATCH_END);
        match_winner = (match_over && right_at_max) ? SIDE_RIGHT : SIDE_LEFT;
    end

    assign L_move      = l_move_q;
    assign R_move      = r_move_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed table-driven bench for match_controller (defaults: 3 points, 4-cycle hold).
module tb_match_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       L_press = 1'b0, R_press = 1'b0;
    logic       win_left = 1'b0, win_right = 1'b0;
    logic       restart = 1'b0;
    logic       L_move, R_move, field_reset, match_over, match_winner;
    logic [2:0] score_left, score_right;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    match_controller #(
        .MATCH_POINTS (3)
`ifdef ROUND_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .L_press      (L_press),
        .R_press      (R_press),
        .win_left     (win_left),
        .win_right    (win_right),
        .restart      (restart),
        .L_move       (L_move),
        .R_move       (R_move),
        .field_reset  (field_reset),
        .score_left   (score_left),
        .score_right  (score_right),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    // stim = {L_press, R_press, win_left, win_right, restart}
    // exp  = {L_move, R_move, field_reset, score_left, score_right, match_over, match_winner}
    typedef struct {
        string      name;
        logic [4:0] stim;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic [4:0] s,
                                input logic lm, input logic rm, input logic fr,
                                input int sl, input int sr,
                                input logic mo, input logic mw);
        vec_t v;
        v.name = n;
        v.stim = s;
        v.exp  = {lm, rm, fr, 3'(sl), 3'(sr), mo, mw};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {L_move, R_move, field_reset, score_left, score_right, match_over, match_winner};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lm rm fr sl sr mo mw = %b %b %b %0d %0d %b %b, want %b %b %b %0d %0d %b %b",
                     name, act[10], act[9], act[8], act[7:5], act[4:2], act[1], act[0],
                     exp[10], exp[9], exp[8], exp[7:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic set_stim(input logic [4:0] s);
        {L_press, R_press, win_left, win_right, restart} = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Main match: one right win, a draw, two more right wins, restart, then two left wins.
        add("to_play",       5'b00000, 0,0,0, 0,0, 0,0);
        add("r_press",       5'b01000, 0,1,0, 0,0, 0,0);
        add("r_idle",        5'b00000, 0,0,0, 0,0, 0,0);
        add("l_press",       5'b10000, 1,0,0, 0,0, 0,0);
        add("both_cancel",   5'b11000, 0,0,0, 0,0, 0,0);
        add("restart_play",  5'b00001, 0,0,0, 0,0, 0,0);
        add("win_r1",        5'b01010, 0,0,0, 0,1, 0,0);
        add("hold1_r_press", 5'b01000, 0,0,0, 0,1, 0,0);
        add("hold2_l_press", 5'b10000, 0,0,0, 0,1, 0,0);
        add("hold3_win_l",   5'b00100, 0,0,0, 0,1, 0,0);
        add("hold4_to_start",5'b01000, 0,0,1, 0,1, 0,0);
        add("play2",         5'b00000, 0,0,0, 0,1, 0,0);
        add("draw",          5'b00110, 0,0,0, 0,1, 0,0);
        add("draw_hold1",    5'b00000, 0,0,0, 0,1, 0,0);
        add("draw_hold2",    5'b00000, 0,0,0, 0,1, 0,0);
        add("draw_hold3",    5'b00000, 0,0,0, 0,1, 0,0);
        add("draw_fr",       5'b00000, 0,0,1, 0,1, 0,0);
        add("play3",         5'b00000, 0,0,0, 0,1, 0,0);
        add("win_r2",        5'b00010, 0,0,0, 0,2, 0,0);
        add("r2_hold1",      5'b00000, 0,0,0, 0,2, 0,0);
        add("r2_hold2",      5'b00000, 0,0,0, 0,2, 0,0);
        add("r2_hold3",      5'b00000, 0,0,0, 0,2, 0,0);
        add("r2_fr",         5'b00000, 0,0,1, 0,2, 0,0);
        add("play4",         5'b00000, 0,0,0, 0,2, 0,0);
        add("win_r3",        5'b00010, 0,0,0, 0,3, 0,0);
        add("hold_restart",  5'b00001, 0,0,0, 0,3, 0,0);
        add("r3_hold2",      5'b00000, 0,0,0, 0,3, 0,0);
        add("r3_hold3",      5'b00000, 0,0,0, 0,3, 0,0);
        add("match_end",     5'b00000, 0,0,0, 0,3, 1,1);
        add("end_ignore",    5'b01100, 0,0,0, 0,3, 1,1);
        add("restart",       5'b00001, 0,0,1, 0,0, 0,0);
        add("play5",         5'b00000, 0,0,0, 0,0, 0,0);
        add("win_l1",        5'b00100, 0,0,0, 1,0, 0,0);
        add("l1_hold1",      5'b00000, 0,0,0, 1,0, 0,0);
        add("l1_hold2",      5'b00000, 0,0,0, 1,0, 0,0);
        add("l1_hold3",      5'b00000, 0,0,0, 1,0, 0,0);
        add("l1_fr",         5'b00000, 0,0,1, 1,0, 0,0);
        add("play6",         5'b00000, 0,0,0, 1,0, 0,0);
        add("win_l2",        5'b00100, 0,0,0, 2,0, 0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 11'b0);
        reset = 1'b1;
        #1;
        check("release_fr", 11'b001_000_000_00);

        for (int i = 0; i < vecs.size(); i++) begin
            set_stim(vecs[i].stim);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end
        set_stim(5'b00000);

        // Asynchronous reset in the middle of the hold with score_left = 2.
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_hold", 11'b0);
        @(posedge clk);
        #1;
        check("reset_held", 11'b0);
        reset = 1'b1;
        #1;
        check("release_fr2", 11'b001_000_000_00);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("restart_in_start", 11'b0);

`ifdef ROUND_TIMEOUT_EN
        // Timer was loaded leaving START; eight PLAY cycles then a draw hold.
        R_press = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("timeout_play_move", 11'b010_000_000_00);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("timeout_hold", {2'b00, (k == 3), 8'b0});
        end
        R_press = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
